inst_fetch_queue: RTL

//   Next-generation instruction fetch: same I-cache request handshake, but decoupled from issue by an IQ_DEPTH-entry instruction queue.

---
 rtl/inst_fetch_queue.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end with an IQ_DEPTH-entry queue between the
// I-cache and the issue stage. Fetch keeps running while issue is stalled.
// JAL and backward branches redirect the fetch PC statically.
//
// Handshakes (both sides use a valid/ready pair):
//   I-cache side: pc_send_enable is the request valid. It rises with
//     pc_to_ic and stays high with a stable address until inst_get_ready
//     (the response valid, one cycle) accepts it, or until a redirect or
//     pause aborts it. A response is only taken while a request is
//     outstanding.
//   Issue side: inst_send_enable is a one-cycle valid for the registered
//     inst/pc/pred outputs. The "ready" is the inverse of
//     rob_full|rs_full|lsb_full. Data outputs hold between pulses.
module inst_fetch_queue #(
  parameter int          IQ_DEPTH       = 8,
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter bit          PREDICT_JAL    = 1'b1,
  parameter bit          PREDICT_BRANCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        pc_send_enable,
  output logic [31:0] pc_to_ic,
  input  logic        inst_get_ready,
  input  logic [31:0] inst_from_ic,
  output logic        inst_send_enable,
  output logic [31:0] inst_to_issue,
  output logic [31:0] pc_to_issue,
  output logic        pred_to_issue,
  input  logic        jump_flag,
  input  logic [31:0] target_pc,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full
);

  localparam int            PW      = $clog2(IQ_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state;
  state_t state_next;

  logic [31:0]         pc;
  logic [31:0]         q_inst [IQ_DEPTH];
  logic [31:0]         q_pc   [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] q_pred;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;

  logic        stall;
  logic        normal;
  logic        do_req;
  logic        do_push;
  logic        do_pop;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic [31:0] next_pc;
  logic        next_pred;

  // Static prediction on the instruction returned for the current pc.
  always_comb begin
    j_imm = {{11{inst_from_ic[31]}}, inst_from_ic[31], inst_from_ic[19:12],
             inst_from_ic[20], inst_from_ic[30:21], 1'b0};
    b_imm = {{19{inst_from_ic[31]}}, inst_from_ic[31], inst_from_ic[7],
             inst_from_ic[30:25], inst_from_ic[11:8], 1'b0};
    next_pc   = pc + 32'd4;
    next_pred = 1'b0;
    if (PREDICT_JAL && (inst_from_ic[6:0] == 7'b1101111)) begin
      next_pc   = pc + j_imm;
      next_pred = 1'b1;
    end else if (PREDICT_BRANCH && (inst_from_ic[6:0] == 7'b1100011) &&
                 inst_from_ic[31]) begin
      next_pc   = pc + b_imm;
      next_pred = 1'b1;
    end
  end

  // Per-cycle actions; a redirect or a pause suppresses all of them.
  always_comb begin
    stall   = rob_full | rs_full | lsb_full;
    normal  = rdy & ~jump_flag;
    do_req  = normal && (state == S_IDLE) && (count < DEPTH_C);
    do_push = normal && (state == S_WAIT) && inst_get_ready;
    do_pop  = normal && !stall && (count != '0);
  end

  // Fetch FSM next state: redirect and pause both drop back to IDLE.
  always_comb begin
    state_next = state;
    if (!normal) begin
      state_next = S_IDLE;
    end else if (do_req) begin
      state_next = S_WAIT;
    end else if (do_push) begin
      state_next = S_IDLE;
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Queue storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (do_push) begin
      q_inst[tail] <= inst_from_ic;
      q_pc[tail]   <= pc;
      q_pred[tail] <= next_pred;
    end
  end

  // PC, request outputs, queue pointers and registered issue outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc               <= RESET_PC;
      pc_send_enable   <= 1'b0;
      pc_to_ic         <= 32'h0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      inst_send_enable <= 1'b0;
      inst_to_issue    <= 32'h0;
      pc_to_issue      <= 32'h0;
      pred_to_issue    <= 1'b0;
    end else begin
      inst_send_enable <= do_pop;
      if (jump_flag) begin
        pc             <= target_pc;
        pc_send_enable <= 1'b0;
        head           <= '0;
        tail           <= '0;
        count          <= '0;
      end else if (!rdy) begin
        // Abort any outstanding request; pc is kept so it is refetched.
        pc_send_enable <= 1'b0;
      end else begin
        if (do_req) begin
          pc_to_ic       <= pc;
          pc_send_enable <= 1'b1;
        end
        if (do_push) begin
          tail           <= tail + PW'(1);
          pc             <= next_pc;
          pc_send_enable <= 1'b0;
        end
        if (do_pop) begin
          inst_to_issue <= q_inst[head];
          pc_to_issue   <= q_pc[head];
          pred_to_issue <= q_pred[head];
          head          <= head + PW'(1);
        end
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

endmodule
